// File: rtl/noc_node_serdes_if.sv
// rtl/noc_node_serdes_if.sv - packet-side and router-side signal bundle for noc_node_serdes
interface noc_node_serdes_if #(
  parameter int PKT_W  = 32,
  parameter int FLIT_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PKT_W-1:0]  pkt_in;
  logic              pkt_in_avail;
  logic              cQ_full;
  logic [CW-1:0]     cQ_count;
  logic [PKT_W-1:0]  pkt_out;
  logic              pkt_out_avail;
  logic              free_outbound;
  logic              put_outbound;
  logic [FLIT_W-1:0] payload_outbound;
  logic              free_inbound;
  logic              put_inbound;
  logic [FLIT_W-1:0] payload_inbound;

  modport slave (
    input  pkt_in, pkt_in_avail, free_outbound, put_inbound, payload_inbound,
    output cQ_full, cQ_count, pkt_out, pkt_out_avail, put_outbound,
           payload_outbound, free_inbound
  );

  modport master (
    output pkt_in, pkt_in_avail, free_outbound, put_inbound, payload_inbound,
    input  cQ_full, cQ_count, pkt_out, pkt_out_avail, put_outbound,
           payload_outbound, free_inbound
  );
endinterface

// File: rtl/noc_node_serdes.sv
// rtl/noc_node_serdes.sv - NoC endpoint: outbound FIFO + flit serialiser, inbound flit deserialiser
// Optional drop counter enabled by NOC_NODE_DROP_CNT_EN.
module noc_node_serdes #(
  parameter int NODEID = 0,
  parameter int PKT_W  = 32,
  parameter int FLIT_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  noc_node_serdes_if.slave    bus
`ifdef NOC_NODE_DROP_CNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);
  localparam int NFLITS = PKT_W / FLIT_W;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int AW     = $clog2(DEPTH);
  localparam int FCW    = $clog2(NFLITS + 1);

  if ((PKT_W % FLIT_W) != 0 || NFLITS < 2 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || NODEID < 0) begin : g_param_check
    $error("noc_node_serdes: invalid parameter combination");
  end

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, push, pop;

  assign full = (count == CW'(DEPTH));
  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign push = bus.pkt_in_avail && !full;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.pkt_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.cQ_full  = full;
  assign bus.cQ_count = count;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} tx_state_t;
  tx_state_t        state, state_next;
  logic [PKT_W-1:0] tx_shift;
  logic [FCW-1:0]   tx_cnt;
  logic             load_flit, finish;
  logic             put_q;
  logic [FLIT_W-1:0] payload_q;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_flit  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop        = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (bus.free_outbound) begin
        load_flit  = 1'b1;
        state_next = SEND;
      end
      SEND: if (tx_cnt == FCW'(NFLITS)) begin
        finish     = 1'b1;
        state_next = IDLE;
      end else begin
        load_flit  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_shift  <= '0;
      tx_cnt    <= '0;
      put_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      if (pop) begin
        tx_shift <= mem[rd_ptr];
        tx_cnt   <= '0;
      end
      if (load_flit) begin
        payload_q <= tx_shift[PKT_W-1 -: FLIT_W];
        tx_shift  <= tx_shift << FLIT_W;
        tx_cnt    <= tx_cnt + 1'b1;
        put_q     <= 1'b1;
      end
      if (finish) put_q <= 1'b0;
    end
  end

  assign bus.put_outbound     = put_q;
  assign bus.payload_outbound = payload_q;

  logic [PKT_W-1:0] rx_asm, rx_next;
  logic [FCW-1:0]   rx_cnt;
  logic [PKT_W-1:0] pkt_out_q;
  logic             avail_q;

  assign rx_next = {rx_asm[PKT_W-FLIT_W-1:0], bus.payload_inbound};

  // rx_cnt parks at NFLITS for one cycle after delivery, keeping free_inbound low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_asm    <= '0;
      rx_cnt    <= '0;
      pkt_out_q <= '0;
      avail_q   <= 1'b0;
    end else begin
      avail_q <= 1'b0;
      if (rx_cnt == FCW'(NFLITS)) begin
        rx_cnt <= '0;
      end else if (bus.put_inbound) begin
        rx_asm <= rx_next;
        rx_cnt <= rx_cnt + 1'b1;
        if (rx_cnt == FCW'(NFLITS - 1)) begin
          pkt_out_q <= rx_next;
          avail_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.pkt_out       = pkt_out_q;
  assign bus.pkt_out_avail = avail_q;
  assign bus.free_inbound  = (rx_cnt == '0);

`ifdef NOC_NODE_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      drop_count <= '0;
    else if (bus.pkt_in_avail && full && drop_count != 8'hFF)
      drop_count <= drop_count + 1'b1;
  end
`endif
endmodule
